counter_share_sched: RTL and testbench

//  Round-robin scheduler that shares one free-running-style WIDTH-bit counter

---
 rtl/counter_share_sched.sv | 129 ++++++++++++
 tb/tb_counter_share_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_share_sched.sv
// counter_share_sched: round-robin sharing of one WIDTH-bit run counter
// between two requesters. The winner owns the counter for its programmed
// length and then receives a one-cycle done pulse.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | no owner; counter holds its last value; arbitrate on req
//   RUN    | owner counts 0..tgt-1, one value per cycle; abort ends early
//   DONE   | single cycle; done pulses to owner, grant/busy still high
module counter_share_sched #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    input  logic             abort,
    output logic [1:0]       grant,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       done,
    output logic             aborted
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic             last, last_nx;
    logic [WIDTH-1:0] tgt, tgt_nx;
    logic [1:0]       grant_nx;
    logic             busy_nx;
    logic [WIDTH-1:0] count_nx;
    logic [1:0]       done_nx;
    logic             aborted_nx;

    logic             win;
    logic [WIDTH-1:0] win_len;

    // Arbitration: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        win = 1'b0;
        if (req == 2'b10) begin
            win = 1'b1;
        end else if (req == 2'b11) begin
            win = ~last;
        end
        win_len = win ? len1 : len0;
    end

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_nx   = state;
        last_nx    = last;
        tgt_nx     = tgt;
        grant_nx   = grant;
        busy_nx    = busy;
        count_nx   = count;
        done_nx    = 2'b00;
        aborted_nx = aborted;

        case (state)
            S_IDLE: begin
                aborted_nx = 1'b0;
                if (req != 2'b00) begin
                    // A zero length still gives one counting cycle.
                    tgt_nx   = (win_len == '0) ? WIDTH'(1) : win_len;
                    grant_nx = win ? 2'b10 : 2'b01;
                    busy_nx  = 1'b1;
                    count_nx = '0;
                    last_nx  = win;
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    aborted_nx = 1'b1;
                    done_nx    = grant;
                    state_nx   = S_DONE;
                end else if (count == tgt - WIDTH'(1)) begin
                    done_nx  = grant;
                    state_nx = S_DONE;
                end else begin
                    count_nx = count + WIDTH'(1);
                end
            end
            S_DONE: begin
                grant_nx   = 2'b00;
                busy_nx    = 1'b0;
                aborted_nx = 1'b0;
                state_nx   = S_IDLE;
            end
            default: begin
                grant_nx   = 2'b00;
                busy_nx    = 1'b0;
                aborted_nx = 1'b0;
                state_nx   = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset leaves the counter at a defined zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            last    <= 1'b1;
            tgt     <= WIDTH'(1);
            grant   <= 2'b00;
            busy    <= 1'b0;
            count   <= '0;
            done    <= 2'b00;
            aborted <= 1'b0;
        end else begin
            state   <= state_nx;
            last    <= last_nx;
            tgt     <= tgt_nx;
            grant   <= grant_nx;
            busy    <= busy_nx;
            count   <= count_nx;
            done    <= done_nx;
            aborted <= aborted_nx;
        end
    end

endmodule

// File: tb/tb_counter_share_sched.sv
// Bench for counter_share_sched: directed scenarios with literal expectations
// followed by random traffic, all checked every cycle against a run-level model.
module tb_counter_share_sched;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [1:0]       req;
    logic [WIDTH-1:0] len0;
    logic [WIDTH-1:0] len1;
    logic             abort;
    logic [1:0]       grant;
    logic             busy;
    logic [WIDTH-1:0] count;
    logic [1:0]       done;
    logic             aborted;

    int n_tests = 0;
    int n_fail  = 0;

    counter_share_sched #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .len0    (len0),
        .len1    (len1),
        .abort   (abort),
        .grant   (grant),
        .busy    (busy),
        .count   (count),
        .done    (done),
        .aborted (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Run-level model: who owns the counter, how far the run has got, and
    // whether this is the closing done cycle.
    int m_owner   = -1;
    int m_len     = 1;
    int m_count   = 0;
    bit m_closing = 1'b0;
    bit m_ab      = 1'b0;
    int m_last    = 1;
    int m_w       = 0;
    int m_lv      = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_owner   = -1;
            m_count   = 0;
            m_closing = 1'b0;
            m_ab      = 1'b0;
            m_last    = 1;
        end else if (m_owner < 0) begin
            if (req != 2'b00) begin
                if (req == 2'b11) m_w = 1 - m_last;
                else              m_w = req[1] ? 1 : 0;
                m_lv    = (m_w == 1) ? int'(len1) : int'(len0);
                m_len   = (m_lv == 0) ? 1 : m_lv;
                m_owner = m_w;
                m_last  = m_w;
                m_count = 0;
            end
        end else if (m_closing) begin
            m_owner   = -1;
            m_closing = 1'b0;
            m_ab      = 1'b0;
        end else if (abort) begin
            m_ab      = 1'b1;
            m_closing = 1'b1;
        end else if (m_count + 1 == m_len) begin
            m_closing = 1'b1;
        end else begin
            m_count = m_count + 1;
        end
    end

    function automatic logic [1:0] m_grant();
        if (m_owner < 0) return 2'b00;
        return (m_owner == 0) ? 2'b01 : 2'b10;
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("grant",   grant,   m_grant());
        chk("busy",    busy,    (m_owner >= 0) ? 1 : 0);
        chk("count",   count,   m_count);
        chk("done",    done,    m_closing ? m_grant() : 2'b00);
        chk("aborted", aborted, m_ab);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    logic [1:0] g2 [5] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    int         c2 [5] = '{0, 1, 2, 2, 2};
    logic [1:0] d2 [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    logic [1:0] g3 [14] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
                            2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
    logic [1:0] d3 [14] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00,
                            2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00};

    initial begin
        rst = 1'b0; req = 2'b00; len0 = '0; len1 = '0; abort = 1'b0;
        step();
        step();
        rst = 1'b1;
        chk("rst_grant", grant, 0);
        chk("rst_busy",  busy,  0);
        chk("rst_count", count, 0);
        chk("rst_done",  done,  0);

        // single run of length 3
        req = 2'b01; len0 = 4'd3;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_grant", grant, g2[i]);
            chk("t2_count", count, c2[i]);
            chk("t2_done",  done,  d2[i]);
            if (i == 0) req = 2'b00;
        end

        // zero length behaves as one
        req = 2'b10; len1 = 4'd0;
        step();
        chk("t4_grant0", grant, 2'b10);
        chk("t4_count0", count, 0);
        req = 2'b00;
        step();
        chk("t4_done", done, 2'b10);
        chk("t4_cnt1", count, 0);
        step();
        chk("t4_idle", grant, 2'b00);

        // tie held from reset alternates r0,r1 with one idle cycle between
        rst = 1'b0; req = 2'b11; len0 = 4'd2; len1 = 4'd1;
        step();
        rst = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            chk("t3_grant", grant, g3[i]);
            chk("t3_done",  done,  d3[i]);
        end
        req = 2'b00;
        step();

        // abort at count 2, then abort while idle
        req = 2'b01; len0 = 4'd10;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) req = 2'b00;
            if (i == 2) begin
                chk("t5_cnt2", count, 2);
                abort = 1'b1;
            end
            if (i == 3) begin
                chk("t5_count",   count,   2);
                chk("t5_aborted", aborted, 1);
                chk("t5_done",    done,    2'b01);
                abort = 1'b0;
            end
            if (i == 4) begin
                chk("t5_idle", grant,   2'b00);
                chk("t5_ab0",  aborted, 0);
            end
        end
        abort = 1'b1;
        step();
        step();
        chk("t5_idle_grant", grant, 2'b00);
        chk("t5_idle_busy",  busy,  0);
        chk("t5_idle_count", count, 2);
        abort = 1'b0;

        // max length, len changed mid-run
        req = 2'b01; len0 = 4'd15;
        step();
        chk("t6_c0", count, 0);
        len0 = 4'd1; req = 2'b00;
        for (int i = 1; i < 15; i++) begin
            step();
            chk("t6_count", count, i);
            chk("t6_grant", grant, 2'b01);
            chk("t6_nodone", done, 2'b00);
        end
        step();
        chk("t6_done",  done,  2'b01);
        chk("t6_cend",  count, 14);
        step();
        chk("t6_idle", grant, 2'b00);

        // asynchronous reset mid-run at count 5
        req = 2'b01; len0 = 4'd10;
        step();
        req = 2'b00;
        for (int i = 0; i < 5; i++) step();
        chk("t1_cnt5", count, 5);
        #2 rst = 1'b0;
        #1;
        chk("t1_grant",   grant,   0);
        chk("t1_busy",    busy,    0);
        chk("t1_count",   count,   0);
        chk("t1_done",    done,    0);
        chk("t1_aborted", aborted, 0);
        step();
        rst = 1'b1; req = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_stay_grant", grant, 0);
            chk("t1_stay_busy",  busy,  0);
        end

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            req   = 2'($urandom_range(0, 3));
            len0  = WIDTH'($urandom);
            len1  = WIDTH'($urandom);
            abort = ($urandom_range(0, 7) == 0);
            rst   = ($urandom_range(0, 299) != 0);
        end
        step();
        rst = 1'b1; req = 2'b00; abort = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
